serial_cmd_engine: RTL and testbench

Byte-stream command processor that sits directly downstream of serial_interface, with I_BYTES=O_BYTES=1. It consumes received bytes from that block's o_data/o_valid/o_ready. It returns response bytes into that block's i_data/i_valid/i_ready. It decodes a 2–3 byte read/write protocol against a small internal register bank, which is exported to the fabric. It replaces the plain loopback in the top level and gives host software register access over UART.

---
 rtl/serial_cmd_engine_pkg.sv | 17 +
 rtl/serial_cmd_engine_if.sv | 22 ++
 rtl/serial_idle_timer.sv | 40 ++++
 rtl/serial_cmd_engine.sv | 145 ++++++++++++++
 tb/tb_serial_cmd_engine.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_cmd_engine_pkg.sv
// Shared definitions for the serial command engine.
// Holds the protocol byte values and the engine FSM state type.
package serial_cmd_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

endpackage

// File: rtl/serial_cmd_engine_if.sv
// Byte-stream handshake bundle between serial_interface and serial_cmd_engine.
//   rx_data/rx_valid/rx_ready : received bytes flowing into the engine
//   tx_data/tx_valid/tx_ready : response bytes flowing out of the engine
// master: the serial_interface side; slave: the command engine.
interface serial_cmd_engine_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/serial_idle_timer.sv
// Inter-byte idle timer for the command engine.
//   clk, rst : clock and synchronous active-high reset
//   clear    : zero the count this cycle (takes priority over run)
//   run      : count one idle cycle
//   expired  : count has reached TIMEOUT_CYCLES-1 while running and not cleared
// TIMEOUT_CYCLES = 0 removes the counter and holds expired low.
module serial_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic w_unused;
    assign w_unused = ^{clk, rst, clear, run};
    assign expired  = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk) begin
      if (rst || clear) begin
        r_cnt <= '0;
      end else if (run) begin
        r_cnt <= r_cnt + CntOne;
      end
    end

    // A byte arriving on the threshold cycle clears the count and wins.
    assign expired = run && !clear && (r_cnt == CntLast);
  end

endmodule

// File: rtl/serial_cmd_engine.sv
// UART register-access command engine.
// Decodes 'W' addr data -> ACK and 'R' addr -> value; anything malformed -> NAK.
//   clk, rst : clock and synchronous active-high reset
//   bus      : rx byte stream in, tx response stream out (slave side)
//   reg_out  : register bank, register k at bits [8k+7:8k]
module serial_cmd_engine
  import serial_cmd_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_cmd_engine_if.slave   bus,
  output logic [DEPTH*8-1:0]   reg_out
);

  state_t     r_state;
  logic       r_rx_ready;
  logic       r_tx_valid;
  logic [7:0] r_tx_data;
  logic [7:0] r_opcode;
  logic [7:0] r_addr;
  logic [7:0] r_regs [DEPTH];

  logic       w_rx_fire;
  logic       w_tx_fire;
  logic       w_rx_addr_ok;
  logic       w_addr_ok;
  logic [7:0] w_rd_data;
  logic       w_expired;
  logic       w_timer_clear;
  logic       w_timer_run;

  assign w_rx_fire = bus.rx_valid && r_rx_ready;
  assign w_tx_fire = r_tx_valid && bus.tx_ready;

  // Full 8-bit compare: out-of-range addresses never alias onto the bank.
  assign w_rx_addr_ok = ({1'b0, bus.rx_data} < 9'(DEPTH));
  assign w_addr_ok    = ({1'b0, r_addr} < 9'(DEPTH));

  always_comb begin
    w_rd_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (bus.rx_data == 8'(k)) w_rd_data = r_regs[k];
    end
  end

  assign w_timer_run   = (r_state == ADDR) || (r_state == DATA);
  assign w_timer_clear = w_rx_fire || !w_timer_run;

  serial_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_timer_clear),
    .run    (w_timer_run),
    .expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rx_ready <= 1'b1;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_opcode   <= 8'h00;
      r_addr     <= 8'h00;
      for (int unsigned k = 0; k < DEPTH; k++) r_regs[k] <= 8'h00;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_rx_fire) begin
            r_opcode <= bus.rx_data;
            if (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ) begin
              r_state <= ADDR;
            end else begin
              r_state    <= RESP;
              r_rx_ready <= 1'b0;
              r_tx_valid <= 1'b1;
              r_tx_data  <= RSP_NAK;
            end
          end
        end
        ADDR: begin
          if (w_rx_fire) begin
            r_addr <= bus.rx_data;
            if (r_opcode == CMD_WRITE) begin
              r_state <= DATA;
            end else begin
              r_state    <= RESP;
              r_rx_ready <= 1'b0;
              r_tx_valid <= 1'b1;
              r_tx_data  <= w_rx_addr_ok ? w_rd_data : RSP_NAK;
            end
          end else if (w_expired) begin
            r_state    <= RESP;
            r_rx_ready <= 1'b0;
            r_tx_valid <= 1'b1;
            r_tx_data  <= RSP_NAK;
          end
        end
        DATA: begin
          if (w_rx_fire) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
              if (w_addr_ok && r_addr == 8'(k)) r_regs[k] <= bus.rx_data;
            end
            r_state    <= RESP;
            r_rx_ready <= 1'b0;
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_addr_ok ? RSP_ACK : RSP_NAK;
          end else if (w_expired) begin
            r_state    <= RESP;
            r_rx_ready <= 1'b0;
            r_tx_valid <= 1'b1;
            r_tx_data  <= RSP_NAK;
          end
        end
        RESP: begin
          // tx_data is held untouched here, so it stays stable under backpressure.
          if (w_tx_fire) begin
            r_state    <= IDLE;
            r_rx_ready <= 1'b1;
            r_tx_valid <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_rx_ready <= 1'b1;
          r_tx_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_ready = r_rx_ready;
  assign bus.tx_valid = r_tx_valid;
  assign bus.tx_data  = r_tx_data;

  for (genvar k = 0; k < DEPTH; k++) begin : g_reg_out
    assign reg_out[8*k +: 8] = r_regs[k];
  end

endmodule

// File: tb/tb_serial_cmd_engine.sv
// Scoreboard bench for serial_cmd_engine (DEPTH=16, TIMEOUT_CYCLES=50).
// Stimulus pushes the expected response byte; a negedge monitor pops and
// compares on every tx transfer.
module tb_serial_cmd_engine;
  import serial_cmd_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TMO   = 50;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [DEPTH*8-1:0]   reg_out;

  serial_cmd_engine_if bus_if ();

  serial_cmd_engine #(
    .DEPTH         (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus_if.slave),
    .reg_out(reg_out)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model[DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] model_vec();
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < DEPTH; k++) v[8*k +: 8] = model[k];
    return v;
  endfunction

  // Monitor: one pop per tx transfer.
  always @(negedge clk) begin
    if (!rst && bus_if.tx_valid && bus_if.tx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_tx: got %02h with no response expected", bus_if.tx_data);
      end else begin
        chk("tx_byte", 128'(bus_if.tx_data), 128'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    while (!bus_if.rx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_checks++;
      $display("FAIL rx_stall: byte %02h not accepted within 200 cycles", b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic cmd_write(input logic [7:0] a, input logic [7:0] d);
    if (a < DEPTH) begin
      exp_q.push_back(RSP_ACK);
      model[a[3:0]] = d;
    end else begin
      exp_q.push_back(RSP_NAK);
    end
    send_byte(CMD_WRITE);
    send_byte(a);
    send_byte(d);
  endtask

  task automatic cmd_read(input logic [7:0] a);
    exp_q.push_back((a < DEPTH) ? model[a[3:0]] : RSP_NAK);
    send_byte(CMD_READ);
    send_byte(a);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d responses still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int t0;
    int t;
    for (int k = 0; k < DEPTH; k++) model[k] = 8'h00;
    bus_if.rx_data  = 8'h00;
    bus_if.rx_valid = 1'b0;
    bus_if.tx_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rx_ready", 128'(bus_if.rx_ready), 128'(1));
    chk("rst_tx_valid", 128'(bus_if.tx_valid), 128'(0));
    chk("rst_tx_data", 128'(bus_if.tx_data), 128'(0));
    chk("rst_regs", reg_out, 128'(0));

    // Write then read
    cmd_write(8'h03, 8'hA5);
    idle();
    drain();
    chk("reg3_written", 128'(reg_out[31:24]), 128'(8'hA5));
    cmd_read(8'h03);
    idle();
    drain();
    chk("regs_after_wr", reg_out, model_vec());

    // Bad opcode, bad write address, bad read address
    exp_q.push_back(RSP_NAK);
    send_byte(8'h41);
    idle();
    chk("badop_tx_valid", 128'(bus_if.tx_valid), 128'(1));
    drain();
    cmd_write(8'h10, 8'hFF);
    cmd_read(8'h20);
    idle();
    drain();
    chk("regs_after_bad", reg_out, model_vec());

    // Timeout after a lone opcode
    exp_q.push_back(RSP_NAK);
    send_byte(CMD_WRITE);
    t0 = cyc;
    t  = 0;
    do begin
      @(negedge clk);
      bus_if.rx_valid = 1'b0;
      t++;
    end while (!bus_if.tx_valid && t < 200);
    chk("timeout_latency", 128'(cyc - t0), 128'(TMO));
    drain();
    cmd_read(8'h00);
    idle();
    drain();
    chk("regs_after_tmo", reg_out, model_vec());

    // Backpressure on a read of reg 0
    cmd_write(8'h00, 8'h5C);
    idle();
    drain();
    @(posedge clk);
    #1 bus_if.tx_ready = 1'b0;
    cmd_read(8'h00);
    idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_tx_valid", 128'(bus_if.tx_valid), 128'(1));
      chk("bp_tx_data", 128'(bus_if.tx_data), 128'(8'h5C));
      chk("bp_rx_ready", 128'(bus_if.rx_ready), 128'(0));
    end
    @(posedge clk);
    #1 bus_if.tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_rel_tx_valid", 128'(bus_if.tx_valid), 128'(0));
    chk("bp_rel_rx_ready", 128'(bus_if.rx_ready), 128'(1));
    chk("bp_one_transfer", 128'(exp_q.size()), 128'(0));

    // Reset in the middle of a write
    send_byte(CMD_WRITE);
    send_byte(8'h01);
    @(negedge clk);
    bus_if.rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) model[k] = 8'h00;
    chk("midrst_tx_valid", 128'(bus_if.tx_valid), 128'(0));
    chk("midrst_rx_ready", 128'(bus_if.rx_ready), 128'(1));
    exp_q.push_back(RSP_NAK);
    send_byte(8'h22);
    idle();
    drain();
    chk("midrst_regs", reg_out, model_vec());

    // Back-to-back stream
    cmd_write(8'h02, 8'h11);
    cmd_write(8'h05, 8'h22);
    cmd_write(8'h0F, 8'h33);
    cmd_read(8'h05);
    cmd_read(8'h0F);
    cmd_read(8'h02);
    idle();
    drain();
    chk("stream_regs", reg_out, model_vec());

    repeat (5) @(negedge clk);
    chk("no_stray_tx", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
